stackcalc_param: RTL

STACKCALC_PARAM -- requirements
Module: stackcalc_param

---
 rtl/stackcalc_pkg.sv | 43 ++++
 rtl/stackcalc_param_if.sv | 28 ++
 rtl/stackcalc_mul.sv | 49 ++++
 rtl/stackcalc_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stackcalc_pkg.sv
// Shared opcode definitions for the stack calculator.
// Also holds the operand-count and stack-growth rules for each opcode.
package stackcalc_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'h0,
        OP_PUSH  = 4'h1,
        OP_POP   = 4'h2,
        OP_DUP   = 4'h3,
        OP_SWAP  = 4'h4,
        OP_OVER  = 4'h5,
        OP_ADD   = 4'h6,
        OP_SUB   = 4'h7,
        OP_AND   = 4'h8,
        OP_OR    = 4'h9,
        OP_XOR   = 4'hA,
        OP_NOT   = 4'hB,
        OP_SHL1  = 4'hC,
        OP_SHR1  = 4'hD,
        OP_MUL   = 4'hE,
        OP_CLEAR = 4'hF
    } op_e;

    // Minimum stack depth an opcode needs before it may execute.
    function automatic logic [1:0] operands_needed(op_e op);
        case (op)
            OP_POP, OP_DUP, OP_NOT, OP_SHL1, OP_SHR1:        return 2'd1;
            OP_SWAP, OP_OVER, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_MUL:                           return 2'd2;
            default:                                         return 2'd0;
        endcase
    endfunction

    function automatic logic grows_stack(op_e op);
        case (op)
            OP_PUSH, OP_DUP, OP_OVER: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stackcalc_param_if.sv
// Command and status bundle between a stack calculator and its controller.
interface stackcalc_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err_under;
    logic             err_over;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, top, count, empty, full, err_under, err_over
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, top, count, empty, full, err_under, err_over
    );
endinterface

// File: rtl/stackcalc_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
// done is high during the cycle whose rising edge retires the final step.
module stackcalc_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNTW-1:0]  cnt_r;
    logic             busy_r;
    logic [WIDTH-1:0] partial_s;

    assign partial_s = mplier_r[0] ? mcand_r : WIDTH'(0);
    assign result    = acc_r + partial_s;
    assign done      = busy_r && (cnt_r == CNTW'(WIDTH - 1));

    // Load operands on start, then accumulate one multiplier bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            cnt_r    <= CNTW'(0);
            acc_r    <= WIDTH'(0);
            mcand_r  <= WIDTH'(0);
            mplier_r <= WIDTH'(0);
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= CNTW'(0);
            acc_r    <= WIDTH'(0);
            mcand_r  <= a;
            mplier_r <= b;
        end else if (busy_r) begin
            acc_r    <= result;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNTW'(1);
            busy_r   <= !done;
        end
    end
endmodule

// File: rtl/stackcalc_param.sv
// Parameterised stack calculator: register-array stack indexed by count,
// single-cycle ops plus an iterative multiply that stalls the command port.
module stackcalc_param
    import stackcalc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    stackcalc_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             ready_r;
    logic             ready_next_s;
    logic             err_under_r;
    logic             err_over_r;

    op_e              op_s;
    logic             accept_s;
    logic             under_s;
    logic             over_s;
    logic [AW-1:0]    tos_idx_s;
    logic [AW-1:0]    nos_idx_s;
    logic [AW-1:0]    new_idx_s;
    logic [WIDTH-1:0] tos_s;
    logic [WIDTH-1:0] nos_s;
    logic [WIDTH-1:0] alu_s;

    logic             wr0_en_s;
    logic [AW-1:0]    wr0_idx_s;
    logic [WIDTH-1:0] wr0_val_s;
    logic             wr1_en_s;
    logic [AW-1:0]    wr1_idx_s;
    logic [WIDTH-1:0] wr1_val_s;
    logic             set_under_s;
    logic             set_over_s;
    logic             clr_err_s;
    logic             mul_start_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_result_s;

    assign op_s      = op_e'(bus.cmd_op);
    assign accept_s  = bus.cmd_valid && ready_r;
    assign tos_idx_s = AW'(count_r - CW'(1));
    assign nos_idx_s = AW'(count_r - CW'(2));
    assign new_idx_s = AW'(count_r);
    assign tos_s     = stack_r[tos_idx_s];
    assign nos_s     = stack_r[nos_idx_s];
    assign under_s   = count_r < CW'(operands_needed(op_s));
    assign over_s    = grows_stack(op_s) && (count_r == CW'(DEPTH));

    assign bus.cmd_ready = ready_r;
    assign bus.count     = count_r;
    assign bus.empty     = (count_r == CW'(0));
    assign bus.full      = (count_r == CW'(DEPTH));
    assign bus.top       = bus.empty ? WIDTH'(0) : tos_s;
    assign bus.err_under = err_under_r;
    assign bus.err_over  = err_over_r;

    stackcalc_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start_s),
        .a      (nos_s),
        .b      (tos_s),
        .done   (mul_done_s),
        .result (mul_result_s)
    );

    // Single-cycle datapath result; binary ops take NOS as the left operand.
    always_comb begin
        alu_s = tos_s;
        case (op_s)
            OP_ADD:  alu_s = nos_s + tos_s;
            OP_SUB:  alu_s = nos_s - tos_s;
            OP_AND:  alu_s = nos_s & tos_s;
            OP_OR:   alu_s = nos_s | tos_s;
            OP_XOR:  alu_s = nos_s ^ tos_s;
            OP_NOT:  alu_s = ~tos_s;
            OP_SHL1: alu_s = tos_s << 1;
            OP_SHR1: alu_s = tos_s >> 1;
            default: alu_s = tos_s;
        endcase
    end

    // Command decode: stack writes, next count and flag updates.
    always_comb begin
        wr0_en_s     = 1'b0;
        wr0_idx_s    = new_idx_s;
        wr0_val_s    = bus.cmd_data;
        wr1_en_s     = 1'b0;
        wr1_idx_s    = nos_idx_s;
        wr1_val_s    = tos_s;
        count_next_s = count_r;
        set_under_s  = 1'b0;
        set_over_s   = 1'b0;
        clr_err_s    = 1'b0;
        mul_start_s  = 1'b0;
        if (mul_done_s) begin
            wr0_en_s     = 1'b1;
            wr0_idx_s    = nos_idx_s;
            wr0_val_s    = mul_result_s;
            count_next_s = count_r - CW'(1);
        end else if (accept_s) begin
            if (op_s == OP_CLEAR) begin
                count_next_s = CW'(0);
                clr_err_s    = 1'b1;
            end else if (under_s) begin
                set_under_s = 1'b1;
            end else if (over_s) begin
                set_over_s = 1'b1;
            end else begin
                case (op_s)
                    OP_PUSH: begin
                        wr0_en_s     = 1'b1;
                        count_next_s = count_r + CW'(1);
                    end
                    OP_POP: count_next_s = count_r - CW'(1);
                    OP_DUP: begin
                        wr0_en_s     = 1'b1;
                        wr0_val_s    = tos_s;
                        count_next_s = count_r + CW'(1);
                    end
                    OP_SWAP: begin
                        wr0_en_s  = 1'b1;
                        wr0_idx_s = tos_idx_s;
                        wr0_val_s = nos_s;
                        wr1_en_s  = 1'b1;
                    end
                    OP_OVER: begin
                        wr0_en_s     = 1'b1;
                        wr0_val_s    = nos_s;
                        count_next_s = count_r + CW'(1);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        wr0_en_s     = 1'b1;
                        wr0_idx_s    = nos_idx_s;
                        wr0_val_s    = alu_s;
                        count_next_s = count_r - CW'(1);
                    end
                    OP_NOT, OP_SHL1, OP_SHR1: begin
                        wr0_en_s  = 1'b1;
                        wr0_idx_s = tos_idx_s;
                        wr0_val_s = alu_s;
                    end
                    OP_MUL:  mul_start_s = 1'b1;
                    default: count_next_s = count_r;
                endcase
            end
        end else begin
            count_next_s = count_r;
        end
    end

    always_comb begin
        if (mul_start_s) begin
            ready_next_s = 1'b0;
        end else if (mul_done_s) begin
            ready_next_s = 1'b1;
        end else begin
            ready_next_s = ready_r;
        end
    end

    // Stack storage holds no reset; entries above count are don't-care.
    always_ff @(posedge clk) begin
        if (wr0_en_s) stack_r[wr0_idx_s] <= wr0_val_s;
        if (wr1_en_s) stack_r[wr1_idx_s] <= wr1_val_s;
    end

    // Control state: count, command-port readiness and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= CW'(0);
            ready_r     <= 1'b1;
            err_under_r <= 1'b0;
            err_over_r  <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            ready_r     <= ready_next_s;
            err_under_r <= clr_err_s ? 1'b0 : (err_under_r | set_under_s);
            err_over_r  <= clr_err_s ? 1'b0 : (err_over_r | set_over_s);
        end
    end
endmodule
